// File: rtl/decrypt_function_1.sv
// decrypt_function_1: two-stage valid/ready decryption, data_1 = x - mask(rand_11), err on borrow/overflow.
// Optional saturating err_count output is enabled by defining DEC1_ERRCNT_EN.
module decrypt_function_1 #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [77:0] inEnc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [59:0] data_1,
  output logic [10:0] rand_11,
  output logic [5:0]  rand_6,
  output logic        err,
  output logic        busy
`ifdef DEC1_ERRCNT_EN
  ,output logic [CNT_W-1:0] err_count
`endif
);

  localparam int unsigned X_W    = 61;
  localparam int unsigned R11_W  = 11;
  localparam int unsigned R6_W   = 6;
  localparam int unsigned D_W    = 60;
  localparam int unsigned DIFF_W = 62;

  logic             r_s1_valid;
  logic [X_W-1:0]   r_s1_x;
  logic [R11_W-1:0] r_s1_r11;
  logic [R6_W-1:0]  r_s1_r6;

  logic              w_s2_load;
  logic              w_in_xfer;
  logic [D_W-1:0]    w_b;
  logic [DIFF_W-1:0] w_diff;

  // S2 refills when empty or draining; S1 advances on the same condition
  assign w_s2_load = !out_valid || out_ready;
  assign in_ready  = !Rst && (!r_s1_valid || w_s2_load);
  assign w_in_xfer = in_valid && in_ready;
  assign busy      = r_s1_valid || out_valid;

  // Mask pattern: r, ~r, ~r, r, ~r in 11-bit slices, topped by r[4:0]
  assign w_b    = {r_s1_r11[4:0], ~r_s1_r11, r_s1_r11, ~r_s1_r11, ~r_s1_r11, r_s1_r11};
  assign w_diff = {1'b0, r_s1_x} - {2'b00, w_b};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_r11   <= '0;
      r_s1_r6    <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_x     <= inEnc[77:17];
      r_s1_r11   <= inEnc[16:6];
      r_s1_r6    <= inEnc[5:0];
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid <= 1'b0;
      data_1    <= '0;
      rand_11   <= '0;
      rand_6    <= '0;
      err       <= 1'b0;
    end else if (w_s2_load) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        data_1  <= w_diff[D_W-1:0];
        rand_11 <= r_s1_r11;
        rand_6  <= r_s1_r6;
        err     <= w_diff[DIFF_W-1] | w_diff[DIFF_W-2];
      end
    end
  end

`ifdef DEC1_ERRCNT_EN
  // Counts delivered faulted words, sticking at all-ones
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err_count <= '0;
    end else if (out_valid && out_ready && err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_decrypt_function_1.sv
// Self-checking bench for decrypt_function_1: directed steps plus random words against a queue-based model.
module tb_decrypt_function_1;

  localparam int unsigned TB_CNT_W = 2;

  logic        Clk;
  logic        Rst;
  logic        in_valid;
  logic        in_ready;
  logic [77:0] inEnc;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] data_1;
  logic [10:0] rand_11;
  logic [5:0]  rand_6;
  logic        err;
  logic        busy;
`ifdef DEC1_ERRCNT_EN
  localparam int unsigned CNT_MAX  = (1 << TB_CNT_W) - 1;
  logic [TB_CNT_W-1:0] err_count;
  int unsigned         cnt_exp;
`endif

  typedef struct {
    logic [59:0] d;
    logic [10:0] r11;
    logic [5:0]  r6;
    logic        e;
  } exp_t;

  exp_t        q[$];
  logic [77:0] src[$];
  int          checks;
  int          errors;
  bit          saw_block;

  decrypt_function_1 #(.CNT_W(TB_CNT_W)) u_dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inEnc     (inEnc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_1    (data_1),
    .rand_11   (rand_11),
    .rand_6    (rand_6),
    .err       (err),
    .busy      (busy)
`ifdef DEC1_ERRCNT_EN
    ,.err_count (err_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mask from its slice rules: 11-bit fields 1, 2 and 4 inverted, r[4:0] on top
  function automatic logic [63:0] mask(input logic [10:0] r);
    logic [63:0] b;
    logic [10:0] f;
    b = 64'd0;
    for (int k = 0; k < 5; k++) begin
      f = (k == 1 || k == 2 || k == 4) ? ~r : r;
      b = b + (64'(f) << (11 * k));
    end
    b = b + (64'(r[4:0]) << 55);
    return b;
  endfunction

  function automatic exp_t model(input logic [77:0] w);
    logic [63:0] x;
    logic [63:0] b;
    exp_t        e;
    x     = 64'(w[77:17]);
    b     = mask(w[16:6]);
    e.r11 = w[16:6];
    e.r6  = w[5:0];
    e.d   = 60'(x - b);
    e.e   = (x < b) || ((x - b) >= (64'd1 << 60));
    return e;
  endfunction

  function automatic logic [77:0] enc(input logic [60:0] x, input logic [10:0] r, input logic [5:0] t);
    return {x, r, t};
  endfunction

  // One clock: check outputs against the scoreboard, then apply the edge's transfers to the model
  task automatic cyc(output bit acc);
    bit   ox;
    exp_t h;
    #1;
    ox  = out_valid && out_ready;
    acc = in_valid && in_ready;
    if (!in_ready) saw_block = 1'b1;
    chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
    chk("busy", 64'(busy), 64'(q.size() != 0));
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        h = q[0];
        chk("data_1", 64'(data_1), 64'(h.d));
        chk("rand_11", 64'(rand_11), 64'(h.r11));
        chk("rand_6", 64'(rand_6), 64'(h.r6));
        chk("err", 64'(err), 64'(h.e));
      end
    end
`ifdef DEC1_ERRCNT_EN
    chk("err_count", 64'(err_count), 64'(cnt_exp));
`endif
    @(posedge Clk);
    @(negedge Clk);
    if (ox && q.size() != 0) begin
`ifdef DEC1_ERRCNT_EN
      if (q[0].e && cnt_exp < CNT_MAX) cnt_exp++;
`endif
      void'(q.pop_front());
    end
    if (acc) q.push_back(model(inEnc));
  endtask

  // mode 0: out_ready high, 1: random out_ready, 2: stall for cycles 3..7
  task automatic run_src(input int mode);
    int c;
    bit a;
    c = 0;
    while ((src.size() != 0 || q.size() != 0) && c < 300) begin
      in_valid = (src.size() != 0);
      if (src.size() != 0) inEnc = src[0];
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(c >= 3 && c < 8);
      endcase
      cyc(a);
      if (a) void'(src.pop_front());
      c++;
    end
    in_valid = 1'b0;
    chk("drain", 64'(src.size() + q.size()), 64'(0));
  endtask

  initial begin
    bit          a;
    logic [59:0] p;
    logic [10:0] r;
    checks    = 0;
    errors    = 0;
    saw_block = 1'b0;
`ifdef DEC1_ERRCNT_EN
    cnt_exp = 0;
`endif
    Rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inEnc     = '0;

    // Reset state
    @(negedge Clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_data_1", 64'(data_1), 64'(0));
    chk("rst_rand_11", 64'(rand_11), 64'(0));
    chk("rst_rand_6", 64'(rand_6), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    @(negedge Clk);
    Rst = 1'b0;

    // Good word: presented after two edges
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inEnc     = enc(61'h7FF001FFFFF801, 11'h000, 6'h2A);
    cyc(a);
    chk("good_acc", 64'(a), 64'(1));
    in_valid = 1'b0;
    #1;
    chk("good_lat1", 64'(out_valid), 64'(0));
    cyc(a);
    #1;
    chk("good_valid", 64'(out_valid), 64'(1));
    chk("good_data", 64'(data_1), 64'h1);
    chk("good_r6", 64'(rand_6), 64'h2A);
    chk("good_err", 64'(err), 64'(0));
    cyc(a);

    // Borrow word
    in_valid = 1'b1;
    inEnc    = enc(61'h0, 11'h000, 6'h01);
    cyc(a);
    in_valid = 1'b0;
    cyc(a);
    #1;
    chk("borrow_data", 64'(data_1), 64'h0F800FFE00000800);
    chk("borrow_err", 64'(err), 64'(1));
    cyc(a);
`ifdef DEC1_ERRCNT_EN
    chk("borrow_cnt", 64'(err_count), 64'(1));
`endif

    // Back-to-back stream of 8 plaintexts with a 5-cycle stall
    for (int i = 0; i < 8; i++) begin
      p = 60'({$urandom(), $urandom()});
      r = 11'($urandom());
      src.push_back(enc(61'(64'(p) + mask(r)), r, 6'(i)));
    end
    saw_block = 1'b0;
    run_src(2);
    chk("stall_blocked", 64'(saw_block), 64'(1));

    // Raw random ciphertexts: exercise borrow and 60-bit overflow under random backpressure
    for (int i = 0; i < 12; i++) begin
      src.push_back(enc(61'({$urandom(), $urandom()}), 11'($urandom()), 6'($urandom())));
    end
    run_src(1);

    // Full pipeline with simultaneous input and output transfer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inEnc     = enc(61'h123456789ABCDEF, 11'h5A5, 6'h11);
    cyc(a);
    inEnc = enc(61'h0FEDCBA98765432, 11'h3C3, 6'h22);
    cyc(a);
    inEnc = enc(61'h1111111111111111, 11'h0F0, 6'h33);
    #1;
    chk("full_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    cyc(a);
    chk("full_both_acc", 64'(a), 64'(1));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("full_busy", 64'(busy), 64'(1));
    chk("full_occ", 64'(in_ready), 64'(0));
    run_src(0);

    // Reset mid-stream with two words in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inEnc     = enc(61'h0, 11'h7FF, 6'h3F);
    cyc(a);
    inEnc = enc(61'h1, 11'h001, 6'h3E);
    cyc(a);
    in_valid = 1'b0;
    #2;
    Rst = 1'b1;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_in_ready", 64'(in_ready), 64'(0));
`ifdef DEC1_ERRCNT_EN
    chk("mrst_cnt", 64'(err_count), 64'(0));
    cnt_exp = 0;
`endif
    q.delete();
    @(negedge Clk);
    Rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    p         = 60'h0ABCDEF01234567;
    r         = 11'h2B4;
    inEnc     = enc(61'(64'(p) + mask(r)), r, 6'h15);
    cyc(a);
    chk("post_acc", 64'(a), 64'(1));
    in_valid = 1'b0;
    #1;
    chk("post_lat1", 64'(out_valid), 64'(0));
    cyc(a);
    #1;
    chk("post_valid", 64'(out_valid), 64'(1));
    chk("post_data", 64'(data_1), 64'(p));
    cyc(a);

`ifdef DEC1_ERRCNT_EN
    // Counter saturation with five faulted words
    for (int i = 0; i < 5; i++) begin
      src.push_back(enc(61'h0, 11'($urandom()), 6'(i)));
    end
    run_src(0);
    chk("cnt_sat", 64'(err_count), 64'(CNT_MAX));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
